// File: rtl/rvm_test_monitor_if.sv
// Signal bundle between the rvm_core test harness and the test-completion monitor.
// The master side drives the address/config/start inputs; the slave side is the monitor.
interface rvm_test_monitor_if #(
  parameter int ADDR_W    = 32,
  parameter int NUM_WATCH = 4,
  parameter int CYC_W     = 32
);
  localparam int IDX_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_addr_valid;
  logic              cfg_wr_en;
  logic [IDX_W-1:0]  cfg_wr_idx;
  logic [ADDR_W-1:0] cfg_wr_addr;
  logic [1:0]        cfg_wr_kind;
  logic [CYC_W-1:0]  cfg_max_cycles;
  logic              start;
  logic              busy;
  logic              done;
  logic              done_pulse;
  logic [2:0]        result;
  logic [IDX_W-1:0]  hit_idx;
  logic [CYC_W-1:0]  cycle_count;

  modport master (
    output mem_addr, mem_addr_valid, cfg_wr_en, cfg_wr_idx, cfg_wr_addr,
           cfg_wr_kind, cfg_max_cycles, start,
    input  busy, done, done_pulse, result, hit_idx, cycle_count
  );

  modport slave (
    input  mem_addr, mem_addr_valid, cfg_wr_en, cfg_wr_idx, cfg_wr_addr,
           cfg_wr_kind, cfg_max_cycles, start,
    output busy, done, done_pulse, result, hit_idx, cycle_count
  );
endinterface

// File: rtl/rvm_test_monitor.sv
// Test-completion monitor: matches the core address bus against a watch table,
// enforces a cycle timeout and latches a single verdict with index and cycle count.
//
// state  | meaning
// S_IDLE | table writable, waiting for start
// S_RUN  | counting cycles, comparing addresses, table locked
// S_DONE | verdict held, table writable, start re-arms
module rvm_test_monitor #(
  parameter int ADDR_W    = 32,
  parameter int NUM_WATCH = 4,
  parameter int CYC_W     = 32
) (
  input  logic                clk,
  input  logic                resetn,
  rvm_test_monitor_if.slave   mon
);
  localparam int IDX_W = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [NUM_WATCH];
  logic [ADDR_W-1:0] addr_d [NUM_WATCH];
  logic [1:0]        kind_q [NUM_WATCH];
  logic [1:0]        kind_d [NUM_WATCH];
  logic [CYC_W-1:0]  limit_q, limit_d;
  logic [CYC_W-1:0]  count_q, count_d;
  logic [2:0]        result_q, result_d;
  logic [IDX_W-1:0]  hit_q, hit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pulse_q, pulse_d;

  logic              match;
  logic [IDX_W-1:0]  match_idx;
  logic [1:0]        match_kind;
  logic              timeout;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match      = 1'b0;
    match_idx  = '0;
    match_kind = 2'd0;
    for (int i = NUM_WATCH - 1; i >= 0; i--) begin
      if (mon.mem_addr_valid && kind_q[i] != 2'd0 && mon.mem_addr == addr_q[i]) begin
        match      = 1'b1;
        match_idx  = IDX_W'(i);
        match_kind = kind_q[i];
      end
    end
  end

  assign timeout = (limit_q != '0) && (count_q == limit_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (mon.start) state_d = S_RUN;
      S_RUN:   if (match || timeout) state_d = S_DONE;
      S_DONE:  if (mon.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    kind_d   = kind_q;
    limit_d  = limit_q;
    count_d  = count_q;
    result_d = result_q;
    hit_d    = hit_q;

    if (state_q != S_RUN && mon.cfg_wr_en &&
        ({1'b0, mon.cfg_wr_idx} < (IDX_W + 1)'(NUM_WATCH))) begin
      addr_d[mon.cfg_wr_idx] = mon.cfg_wr_addr;
      kind_d[mon.cfg_wr_idx] = mon.cfg_wr_kind;
    end

    if (state_q != S_RUN && mon.start) begin
      count_d  = '0;
      limit_d  = mon.cfg_max_cycles;
      result_d = 3'd0;
      hit_d    = '0;
    end else if (state_q == S_RUN) begin
      if (match) begin
        hit_d = match_idx;
        unique case (match_kind)
          2'd1:    result_d = 3'd4;
          2'd2:    result_d = 3'd1;
          default: result_d = 3'd2;
        endcase
      end else if (timeout) begin
        result_d = 3'd3;
        hit_d    = '0;
      end else if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end
    end

    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    pulse_d = (state_q == S_RUN) && (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < NUM_WATCH; i++) begin
        addr_q[i] <= '0;
        kind_q[i] <= 2'd0;
      end
      limit_q  <= '0;
      count_q  <= '0;
      result_q <= 3'd0;
      hit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      kind_q   <= kind_d;
      limit_q  <= limit_d;
      count_q  <= count_d;
      result_q <= result_d;
      hit_q    <= hit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
    end
  end

  assign mon.busy        = busy_q;
  assign mon.done        = done_q;
  assign mon.done_pulse  = pulse_q;
  assign mon.result      = result_q;
  assign mon.hit_idx     = hit_q;
  assign mon.cycle_count = count_q;
endmodule

// File: tb/tb_rvm_test_monitor.sv
// Directed bench for rvm_test_monitor; expected verdicts are queued when a run is
// armed and popped when the monitor raises done_pulse.
module tb_rvm_test_monitor;
  localparam int ADDR_W    = 32;
  localparam int NUM_WATCH = 4;
  localparam int CYC_W     = 32;

  typedef struct {
    logic [2:0]  res;
    logic [1:0]  idx;
    logic [31:0] cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  rvm_test_monitor_if #(.ADDR_W(ADDR_W), .NUM_WATCH(NUM_WATCH), .CYC_W(CYC_W)) mon();

  rvm_test_monitor #(.ADDR_W(ADDR_W), .NUM_WATCH(NUM_WATCH), .CYC_W(CYC_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mon    (mon)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] addr, input logic [1:0] kind);
    mon.cfg_wr_en   = 1'b1;
    mon.cfg_wr_idx  = 2'(idx);
    mon.cfg_wr_addr = addr;
    mon.cfg_wr_kind = kind;
    tick();
    mon.cfg_wr_en   = 1'b0;
  endtask

  task automatic arm(input logic [31:0] limit);
    mon.cfg_max_cycles = limit;
    mon.start          = 1'b1;
    tick();
    mon.start          = 1'b0;
  endtask

  task automatic hit_addr(input logic [31:0] addr);
    mon.mem_addr       = addr;
    mon.mem_addr_valid = 1'b1;
    tick();
    mon.mem_addr_valid = 1'b0;
  endtask

  task automatic wait_verdict(input string tag, input int max_cyc);
    int   n;
    exp_t e;
    n = 0;
    while (mon.done_pulse !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, "_pulse"}, mon.done_pulse, 1);
    e = sb.pop_front();
    chk({tag, "_done"},   mon.done, 1);
    chk({tag, "_busy"},   mon.busy, 0);
    chk({tag, "_result"}, mon.result, e.res);
    chk({tag, "_hit"},    mon.hit_idx, e.idx);
    chk({tag, "_cycles"}, mon.cycle_count, e.cyc);
    tick();
    chk({tag, "_pulse_end"}, mon.done_pulse, 0);
    chk({tag, "_held"},      mon.done, 1);
    chk({tag, "_res_held"},  mon.result, e.res);
    chk({tag, "_cyc_held"},  mon.cycle_count, e.cyc);
  endtask

  initial begin
    int early;
    resetn             = 1'b0;
    mon.mem_addr       = '0;
    mon.mem_addr_valid = 1'b0;
    mon.cfg_wr_en      = 1'b0;
    mon.cfg_wr_idx     = '0;
    mon.cfg_wr_addr    = '0;
    mon.cfg_wr_kind    = 2'd0;
    mon.cfg_max_cycles = '0;
    mon.start          = 1'b0;
    #12;
    chk("rst_busy",   mon.busy, 0);
    chk("rst_done",   mon.done, 0);
    chk("rst_pulse",  mon.done_pulse, 0);
    chk("rst_result", mon.result, 0);
    chk("rst_hit",    mon.hit_idx, 0);
    chk("rst_cycles", mon.cycle_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // PASS hit after 20 run cycles
    cfg_write(0, 32'h100, 2'd2);
    sb.push_back('{3'd1, 2'd0, 32'd20});
    arm(32'd500);
    chk("t1_busy", mon.busy, 1);
    chk("t1_cnt0", mon.cycle_count, 0);
    repeat (20) tick();
    hit_addr(32'h100);
    wait_verdict("t1", 5);

    // lowest index wins; configured from DONE, then re-armed
    cfg_write(1, 32'h200, 2'd3);
    cfg_write(3, 32'h200, 2'd2);
    sb.push_back('{3'd2, 2'd1, 32'd3});
    arm(32'd0);
    chk("rearm_busy",   mon.busy, 1);
    chk("rearm_done",   mon.done, 0);
    chk("rearm_result", mon.result, 0);
    chk("rearm_hit",    mon.hit_idx, 0);
    chk("rearm_cycles", mon.cycle_count, 0);
    repeat (3) tick();
    hit_addr(32'h200);
    wait_verdict("t2", 5);

    // timeout at 10
    sb.push_back('{3'd3, 2'd0, 32'd10});
    arm(32'd10);
    wait_verdict("t3", 30);

    // limit 0 never times out
    sb.push_back('{3'd1, 2'd0, 32'd1000});
    arm(32'd0);
    early = 0;
    repeat (1000) begin
      tick();
      if (mon.done !== 1'b0) early = 1;
    end
    chk("t3b_no_done", early, 0);
    chk("t3b_busy",    mon.busy, 1);
    chk("t3b_cycles",  mon.cycle_count, 1000);
    hit_addr(32'h100);
    wait_verdict("t3b", 5);

    // match at cycle_count == limit beats timeout
    sb.push_back('{3'd1, 2'd0, 32'd5});
    arm(32'd5);
    repeat (5) tick();
    chk("t4_cnt", mon.cycle_count, 5);
    hit_addr(32'h100);
    wait_verdict("t4", 5);

    // invalid address never matches; writes during RUN are ignored
    cfg_write(2, 32'h0, 2'd1);
    sb.push_back('{3'd4, 2'd2, 32'd50});
    mon.mem_addr = 32'h0;
    arm(32'd0);
    repeat (20) tick();
    mon.cfg_wr_en   = 1'b1;
    mon.cfg_wr_idx  = 2'd0;
    mon.cfg_wr_addr = 32'h0;
    mon.cfg_wr_kind = 2'd3;
    tick();
    mon.cfg_wr_en   = 1'b0;
    repeat (29) tick();
    chk("t5_done", mon.done, 0);
    chk("t5_busy", mon.busy, 1);
    chk("t5_cnt",  mon.cycle_count, 50);
    hit_addr(32'h0);
    wait_verdict("t5", 5);

    // async reset mid-run clears outputs and table
    arm(32'd0);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    chk("t6_busy",   mon.busy, 0);
    chk("t6_done",   mon.done, 0);
    chk("t6_result", mon.result, 0);
    chk("t6_hit",    mon.hit_idx, 0);
    chk("t6_cycles", mon.cycle_count, 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    sb.push_back('{3'd3, 2'd0, 32'd20});
    mon.mem_addr       = 32'h100;
    mon.mem_addr_valid = 1'b1;
    arm(32'd20);
    wait_verdict("t6", 40);
    mon.mem_addr_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvm_test_monitor.md
Name: rvm_test_monitor

Overview:
Synthesisable, parametrised simulation/FPGA test-completion monitor for the rvm_core.
- Watches the core's memory address bus against a programmable table of NUM_WATCH addresses.
- Each table entry is tagged HALT, PASS or FAIL; a run-cycle timeout is also enforced.
- Latches a single verdict, the matching entry index and the cycle count, so benches and on-chip harnesses share one termination mechanism.

Parameters:
- ADDR_W, 32: width of monitored address and table entries.
- NUM_WATCH, 4: number of watch-table entries (1..16).
- CYC_W, 32: width of cycle counter and timeout limit.
- IDX_W (localparam): max(1, clog2(NUM_WATCH)).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- mem_addr  in  ADDR_W  core memory address.
- mem_addr_valid  in  1  qualifies mem_addr for comparison this cycle.
- cfg_wr_en  in  1  write one watch-table entry.
- cfg_wr_idx  in  IDX_W  entry to write.
- cfg_wr_addr  in  ADDR_W  address stored in entry.
- cfg_wr_kind  in  2  0=DISABLED, 1=HALT, 2=PASS, 3=FAIL.
- cfg_max_cycles  in  CYC_W  timeout limit; 0 disables timeout; sampled on start.
- start  in  1  arm monitor, begin counting.
- busy  out  1  monitor in RUN.
- done  out  1  verdict latched (level).
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- result  out  3  0=NONE, 1=PASS, 2=FAIL_ADDR, 3=TIMEOUT, 4=HALT.
- hit_idx  out  IDX_W  matching entry index (0 for TIMEOUT/NONE).
- cycle_count  out  CYC_W  current/final cycle count.

Behaviour:
- Reset (async, resetn=0):
  - State IDLE.
  - All table kinds DISABLED, addresses 0, limit register 0.
  - busy=0, done=0, done_pulse=0, result=0, hit_idx=0, cycle_count=0.
  - Reset mid-RUN aborts with no verdict.
- States IDLE, RUN, DONE. All outputs registered.
- IDLE:
  - cfg_wr_en writes entry cfg_wr_idx on the clock edge; idx >= NUM_WATCH is ignored.
  - start -> RUN next cycle; cycle_count<=0; limit<=cfg_max_cycles.
- RUN:
  - cycle_count increments by 1 each cycle, saturating at all-ones.
  - cfg_wr_en is ignored; start is ignored.
  - Match: mem_addr_valid=1 and mem_addr==entry.addr for a non-DISABLED entry.
  - Multiple matches: lowest index wins.
  - Match or timeout -> DONE on the same edge. done=1, busy=0 and done_pulse=1 become visible the cycle after the sampled match (1-cycle latency).
  - result from the winning kind (PASS->1, FAIL->2, HALT->4); hit_idx = winning index.
  - Timeout: limit!=0 and cycle_count==limit with no match -> result=3.
  - A match in the same cycle beats timeout.
  - cycle_count freezes on the transition edge at its current value (not incremented).
- DONE:
  - result, hit_idx, cycle_count and done held.
  - done_pulse deasserts after one cycle.
  - cfg_wr_en is accepted.
  - start -> RUN, clearing done/result/hit_idx/cycle_count (re-arm).
- Duplicate addresses across entries are legal; priority rule applies.
- mem_addr_valid=0 never matches, including against address 0 entries.

Test Plan:
- Entry0=PASS@0x100, limit 500, start; drive valid 0x100 after 20 RUN cycles -> next cycle done=1, done_pulse for exactly 1 cycle, result=1, hit_idx=0, cycle_count=20.
- Entry1=FAIL@0x200, entry3=PASS@0x200; hit 0x200 -> result=2, hit_idx=1 (lowest index wins).
- limit=10, no matching addresses -> done after cycle_count reaches 10, result=3, cycle_count=10. Repeat with limit=0 for 1000 cycles -> busy stays 1, done=0.
- limit=5 with PASS address presented exactly when cycle_count==5 -> result=1, not 3.
- Entry2=HALT@0x0; drive 0x0 with valid=0 for 50 cycles -> no verdict. Then valid=1 -> result=4, hit_idx=2. Config write to entry2 during RUN -> ignored.
- Deassert resetn mid-RUN -> all outputs 0 immediately (async), table disabled. Re-arm from DONE via start -> outputs cleared, busy=1 next cycle.
